// File: rtl/mp_pkg.sv
// Shared definitions for the word-serial multi-precision add/subtract blocks.
// Holds default widths, the word-count helpers and the common FSM state type.
package mp_pkg;

  localparam int MP_WIDTH  = 256;
  localparam int MP_WORD_W = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CALC = 1'b1
  } mp_state_e;

  // Number of compute cycles for one full-width operation.
  function automatic int mp_num_words(input int width, input int word_w);
    return width / word_w;
  endfunction

  // Counter width able to index every word; at least one bit.
  function automatic int mp_cnt_bits(input int num_words);
    return (num_words <= 1) ? 1 : $clog2(num_words);
  endfunction

endpackage

// File: rtl/mpsub_word.sv
// One word of the multi-precision subtractor: diff = a - b - borrow_in,
// evaluated one bit wider so the top bit is the outgoing borrow.
module mpsub_word #(
  parameter int WORD_W = 32
) (
  input  logic [WORD_W-1:0] i_a,
  input  logic [WORD_W-1:0] i_b,
  input  logic              i_borrow,
  output logic [WORD_W-1:0] o_diff,
  output logic              o_borrow
);

  logic [WORD_W:0] w_full;

  // The result is negative exactly when a < b + borrow_in; the magnitude never
  // exceeds 2^WORD_W, so bit WORD_W is the borrow.
  assign w_full   = {1'b0, i_a} - {1'b0, i_b} - {{WORD_W{1'b0}}, i_borrow};
  assign o_diff   = w_full[WORD_W-1:0];
  assign o_borrow = w_full[WORD_W];

endmodule

// File: rtl/mpsub256.sv
// Word-serial multi-precision subtractor: d_out = {borrow, a - b}, one
// WORD_W slice per cycle, least significant word first.
module mpsub256
  import mp_pkg::*;
#(
  parameter int WIDTH  = MP_WIDTH,
  parameter int WORD_W = MP_WORD_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             write,
  input  logic             start,
  output logic [WIDTH:0]   d_out,
  output logic             ready,
  output mp_state_e        o_dbg_state
);

  localparam int NUM_WORDS = mp_num_words(WIDTH, WORD_W);
  localparam int CNT_W     = mp_cnt_bits(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);

  // Handshake: write and start are single-cycle requests honoured only in
  // IDLE, write taking priority when both are high. Either one drops ready on
  // the next edge. ready rises NUM_WORDS edges after an accepted start, and
  // d_out is valid and held while ready=1 until the next accepted request.
  mp_state_e          r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_borrow;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH:0]     r_d;
  logic               r_ready;

  logic [WORD_W-1:0]  w_a_word;
  logic [WORD_W-1:0]  w_b_word;
  logic [WORD_W-1:0]  w_diff;
  logic               w_borrow_out;
  logic               w_last;

  always_comb begin
    w_a_word = r_a[int'(r_cnt) * WORD_W +: WORD_W];
    w_b_word = r_b[int'(r_cnt) * WORD_W +: WORD_W];
  end

  assign w_last = (r_cnt == LAST_WORD);

  mpsub_word #(
    .WORD_W(WORD_W)
  ) u_word (
    .i_a      (w_a_word),
    .i_b      (w_b_word),
    .i_borrow (r_borrow),
    .o_diff   (w_diff),
    .o_borrow (w_borrow_out)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_d      <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (write) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_ready <= 1'b0;
          end else if (start) begin
            r_state  <= ST_CALC;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_ready  <= 1'b0;
          end
        end
        ST_CALC: begin
          // Operands are frozen here; write/start are deliberately not looked at.
          r_d[int'(r_cnt) * WORD_W +: WORD_W] <= w_diff;
          r_borrow <= w_borrow_out;
          if (w_last) begin
            r_d[WIDTH] <= w_borrow_out;
            r_ready    <= 1'b1;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign d_out       = r_d;
  assign ready       = r_ready;
  assign o_dbg_state = r_state;

endmodule
